conv_stream_master: RTL and testbench

- Stream-side master that drives the convolution engine's X and F slave inputs and absorbs its Y output.
- Holds one X vector and one F vector in local register buffers, loaded through a simple write port.
- On `start`, transmits both vectors over independent valid/ready streams, captures every Y result into a result buffer, and pulses `done`.
- Used as the on-chip source/sink in front of the convolution block and as the bench driver.

---
 rtl/conv_stream_master_if.sv | 29 ++
 rtl/conv_stream_master.sv | 105 ++++++++++
 tb/tb_conv_stream_master.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_master_if.sv
// Stream bundle between conv_stream_master and the convolution engine:
// X and F source streams plus the Y result sink.
interface conv_stream_master_if #(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int ACC_SIZE     = 18
);
  // A beat transfers on a rising edge where valid && ready; the source holds
  // valid and data stable until that edge and never drops valid without a transfer.
  logic                    m_valid_x;
  logic [DATA_WIDTH_X-1:0] m_data_x;
  logic                    s_ready_x;
  logic                    m_valid_f;
  logic [DATA_WIDTH_F-1:0] m_data_f;
  logic                    s_ready_f;
  logic                    s_valid_y;
  logic [ACC_SIZE-1:0]     s_data_y;
  logic                    s_ready_y;

  modport master (
    output m_valid_x, m_data_x, m_valid_f, m_data_f, s_ready_y,
    input  s_ready_x, s_ready_f, s_valid_y, s_data_y
  );

  modport slave (
    input  m_valid_x, m_data_x, m_valid_f, m_data_f, s_ready_y,
    output s_ready_x, s_ready_f, s_valid_y, s_data_y
  );
endinterface

// File: rtl/conv_stream_master.sv
// Source/sink for the convolution engine: streams buffered X and F vectors out
// on start, captures NUM_Y results into a readable buffer, then pulses done.
module conv_stream_master #(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int X_SIZE       = 8,
  parameter int F_SIZE       = 4,
  parameter int ACC_SIZE     = 18,
  parameter int NUM_Y        = X_SIZE - F_SIZE + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ld_en,
  input  logic                      ld_sel,
  input  logic [$clog2(X_SIZE)-1:0] ld_addr,
  input  logic [DATA_WIDTH_X-1:0]   ld_data,
  input  logic                      start,
  input  logic                      y_stall,
  conv_stream_master_if.master      bus,
  output logic                      busy,
  output logic                      done,
  input  logic [$clog2(NUM_Y)-1:0]  rd_addr,
  output logic [ACC_SIZE-1:0]       rd_data,
  output logic [1:0]                dbg_state_o
);
  localparam int XAW = $clog2(X_SIZE);
  localparam int FAW = $clog2(F_SIZE);
  localparam int YAW = $clog2(NUM_Y);
  localparam int XCW = $clog2(X_SIZE + 1);
  localparam int FCW = $clog2(F_SIZE + 1);
  localparam int YCW = $clog2(NUM_Y + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_e;

  state_e                  state_q;
  logic [XCW-1:0]          x_cnt_q;
  logic [FCW-1:0]          f_cnt_q;
  logic [YCW-1:0]          y_cnt_q;
  logic [DATA_WIDTH_X-1:0] xbuf_q [X_SIZE];
  logic [DATA_WIDTH_F-1:0] fbuf_q [F_SIZE];
  logic [ACC_SIZE-1:0]     ybuf_q [NUM_Y];

  logic x_full, f_full, y_full;
  logic x_fire, f_fire, y_fire;

  assign x_full = (x_cnt_q == XCW'(X_SIZE));
  assign f_full = (f_cnt_q == FCW'(F_SIZE));
  assign y_full = (y_cnt_q == YCW'(NUM_Y));

  assign bus.m_valid_x = (state_q == RUN) && !x_full;
  assign bus.m_valid_f = (state_q == RUN) && !f_full;
  assign bus.s_ready_y = (state_q == RUN) && !y_full && !y_stall;
  // Once a counter is full its index wraps; data is don't-care with valid low.
  assign bus.m_data_x  = xbuf_q[x_cnt_q[XAW-1:0]];
  assign bus.m_data_f  = fbuf_q[f_cnt_q[FAW-1:0]];

  assign x_fire = bus.m_valid_x && bus.s_ready_x;
  assign f_fire = bus.m_valid_f && bus.s_ready_f;
  assign y_fire = bus.s_valid_y && bus.s_ready_y;

  assign busy        = (state_q == RUN);
  assign done        = (state_q == FIN);
  assign dbg_state_o = state_q;
  assign rd_data     = (32'(rd_addr) < NUM_Y) ? ybuf_q[rd_addr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_cnt_q <= '0;
      f_cnt_q <= '0;
      y_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            x_cnt_q <= '0;
            f_cnt_q <= '0;
            y_cnt_q <= '0;
          end
        end
        RUN: begin
          if (x_fire) x_cnt_q <= x_cnt_q + XCW'(1);
          if (f_fire) f_cnt_q <= f_cnt_q + FCW'(1);
          if (y_fire) y_cnt_q <= y_cnt_q + YCW'(1);
          if (x_full && f_full && y_full) state_q <= FIN;
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffers keep their contents through reset; loads only land while idle.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && ld_en) begin
      if (!ld_sel) xbuf_q[ld_addr] <= ld_data;
      else         fbuf_q[ld_addr[FAW-1:0]] <= ld_data[DATA_WIDTH_F-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (y_fire) ybuf_q[y_cnt_q[YAW-1:0]] <= bus.s_data_y;
  end
endmodule

// File: tb/tb_conv_stream_master.sv
// Directed/randomized bench for conv_stream_master with a behavioural engine
// that consumes X/F beats and returns the sliding dot products as Y beats.
module tb_conv_stream_master;
  localparam int DWX   = 8;
  localparam int DWF   = 8;
  localparam int XS    = 8;
  localparam int FS    = 4;
  localparam int ACC_W = 18;
  localparam int NY    = XS - FS + 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    ld_en, ld_sel, start, y_stall;
  logic [$clog2(XS)-1:0]   ld_addr;
  logic [DWX-1:0]          ld_data;
  logic                    busy, done;
  logic [$clog2(NY)-1:0]   rd_addr;
  logic [ACC_W-1:0]        rd_data;
  logic [1:0]              dbg_state;

  conv_stream_master_if #(.DATA_WIDTH_X(DWX), .DATA_WIDTH_F(DWF), .ACC_SIZE(ACC_W)) bus ();

  conv_stream_master #(
    .DATA_WIDTH_X(DWX), .DATA_WIDTH_F(DWF), .X_SIZE(XS), .F_SIZE(FS), .ACC_SIZE(ACC_W)
  ) dut (
    .clk(clk), .reset(rst_n), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .y_stall(y_stall), .bus(bus), .busy(busy),
    .done(done), .rd_addr(rd_addr), .rd_data(rd_data), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference data as loaded into the DUT
  logic [DWX-1:0] x_ld [XS];
  logic [DWF-1:0] f_ld [FS];

  // engine state
  logic [DWX-1:0] rx_q [$];
  logic [DWF-1:0] rf_q [$];
  int             y_idx;
  bit             y_fire, x_pend, f_pend;
  logic [DWX-1:0] x_pend_d;
  logic [DWF-1:0] f_pend_d;
  bit             x_rand, f_rand, x_hold, f_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_y(int j);
    int s = 0;
    for (int k = 0; k < FS; k++) s += int'($signed(x_ld[j + k])) * int'($signed(f_ld[k]));
    return s;
  endfunction

  // Engine: decides ready/valid at the falling edge, records beats that will
  // transfer at the next rising edge, and checks source stability under backpressure.
  always @(negedge clk) begin
    int acc;
    bus.s_ready_x = !x_hold && (x_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    bus.s_ready_f = !f_hold && (f_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    if (!rst_n) begin
      y_fire = 0; x_pend = 0; f_pend = 0;
      bus.s_valid_y = 1'b0;
      bus.s_data_y  = '0;
    end else begin
      if (y_fire) y_idx++;
      if (y_idx < NY && rf_q.size() == FS && rx_q.size() >= y_idx + FS) begin
        acc = 0;
        for (int k = 0; k < FS; k++) acc += int'($signed(rx_q[y_idx + k])) * int'($signed(rf_q[k]));
        bus.s_valid_y = 1'b1;
        bus.s_data_y  = acc[ACC_W-1:0];
      end else begin
        bus.s_valid_y = 1'b0;
      end
      if (x_pend) chk("x_hold_stable", {bus.m_valid_x, bus.m_data_x}, {1'b1, x_pend_d});
      if (f_pend) chk("f_hold_stable", {bus.m_valid_f, bus.m_data_f}, {1'b1, f_pend_d});
      x_pend = bus.m_valid_x && !bus.s_ready_x;
      x_pend_d = bus.m_data_x;
      f_pend = bus.m_valid_f && !bus.s_ready_f;
      f_pend_d = bus.m_data_f;
      if (bus.m_valid_x && bus.s_ready_x) rx_q.push_back(bus.m_data_x);
      if (bus.m_valid_f && bus.s_ready_f) rf_q.push_back(bus.m_data_f);
      y_fire = bus.s_valid_y && bus.s_ready_y;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic engine_clear();
    rx_q.delete();
    rf_q.delete();
    y_idx = 0; y_fire = 0; x_pend = 0; f_pend = 0;
    bus.s_valid_y = 1'b0;
  endtask

  task automatic load_vectors();
    for (int i = 0; i < XS; i++) begin
      ld_en = 1; ld_sel = 0; ld_addr = i[$clog2(XS)-1:0]; ld_data = x_ld[i];
      tick();
    end
    for (int k = 0; k < FS; k++) begin
      ld_en = 1; ld_sel = 1; ld_addr = k[$clog2(XS)-1:0]; ld_data = f_ld[k];
      tick();
    end
    ld_en = 0;
  endtask

  task automatic start_run(input string tag);
    engine_clear();
    start = 1;
    tick();
    start = 0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_first_x_valid"}, bus.m_valid_x, 1);
  endtask

  task automatic wait_done(input string tag);
    int seen = 0;
    for (int c = 0; c < 600 && seen == 0; c++) begin
      tick();
      if (done) seen++;
    end
    chk({tag, "_done_seen"}, seen, 1);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done) seen++;
    end
    chk({tag, "_done_once"}, seen, 1);
  endtask

  task automatic check_results(input string tag);
    logic [ACC_W-1:0] ye;
    chk({tag, "_x_beats"}, rx_q.size(), XS);
    chk({tag, "_f_beats"}, rf_q.size(), FS);
    for (int i = 0; i < XS; i++)
      chk($sformatf("%s_x%0d", tag, i), (i < rx_q.size()) ? rx_q[i] : 32'hdead, x_ld[i]);
    for (int k = 0; k < FS; k++)
      chk($sformatf("%s_f%0d", tag, k), (k < rf_q.size()) ? rf_q[k] : 32'hdead, f_ld[k]);
    for (int j = 0; j < NY; j++) begin
      rd_addr = j[$clog2(NY)-1:0];
      #1;
      ye = ACC_W'(model_y(j));
      chk($sformatf("%s_y%0d", tag, j), rd_data, ye);
    end
    chk({tag, "_idle_ready_y"}, bus.s_ready_y, 0);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < XS; i++) x_ld[i] = DWX'($urandom_range(0, 255));
    for (int k = 0; k < FS; k++) f_ld[k] = DWF'($urandom_range(0, 255));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst_n = 0; ld_en = 0; ld_sel = 0; ld_addr = '0; ld_data = '0;
    start = 0; y_stall = 0; rd_addr = '0;
    x_rand = 0; f_rand = 0; x_hold = 0; f_hold = 0;
    engine_clear();
    tick();
    tick();
    chk("rst_valid_x", bus.m_valid_x, 0);
    chk("rst_valid_f", bus.m_valid_f, 0);
    chk("rst_ready_y", bus.s_ready_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1;
    tick();

    // 1: ramp with unity filter
    for (int i = 0; i < XS; i++) x_ld[i] = DWX'(i + 1);
    for (int k = 0; k < FS; k++) f_ld[k] = DWF'(1);
    load_vectors();
    start_run("ramp");
    wait_done("ramp");
    check_results("ramp");

    // 2: most negative values, result must not lose sign bits
    for (int i = 0; i < XS; i++) x_ld[i] = 8'h80;
    for (int k = 0; k < FS; k++) f_ld[k] = 8'h80;
    load_vectors();
    start_run("neg");
    wait_done("neg");
    check_results("neg");

    // 3: random X backpressure, F held off for 20 cycles
    randomize_data();
    load_vectors();
    x_rand = 1; f_hold = 1;
    start_run("bp");
    repeat (20) tick();
    chk("bp_f_held", rf_q.size(), 0);
    f_hold = 0; f_rand = 1;
    wait_done("bp");
    check_results("bp");
    x_rand = 0; f_rand = 0;

    // 4: Y stall for 15 cycles
    randomize_data();
    load_vectors();
    y_stall = 1;
    start_run("stall");
    snap = y_idx;
    for (int c = 0; c < 15; c++) begin
      chk("stall_ready_y", bus.s_ready_y, 0);
      tick();
    end
    chk("stall_no_capture", y_idx + int'(y_fire), snap);
    y_stall = 0;
    wait_done("stall");
    check_results("stall");

    // 5: reset after 3 X beats, then a full rerun
    randomize_data();
    load_vectors();
    start_run("abort");
    for (int c = 0; c < 50 && rx_q.size() < 3; c++) tick();
    chk("abort_3_beats", rx_q.size(), 3);
    rst_n = 0;
    #1;
    chk("abort_valid_x", bus.m_valid_x, 0);
    chk("abort_valid_f", bus.m_valid_f, 0);
    chk("abort_ready_y", bus.s_ready_y, 0);
    chk("abort_busy", busy, 0);
    tick();
    chk("abort_done", done, 0);
    tick();
    rst_n = 1;
    tick();
    start_run("rerun");
    wait_done("rerun");
    check_results("rerun");

    // 6: start and ld_en while busy are ignored
    randomize_data();
    load_vectors();
    x_hold = 1;
    start_run("ign");
    tick();
    ld_en = 1; ld_sel = 0; ld_addr = '0; ld_data = ~x_ld[0]; start = 1;
    tick();
    ld_sel = 1; ld_data = ~f_ld[0];
    tick();
    ld_en = 0; start = 0; x_hold = 0;
    wait_done("ign");
    check_results("ign");
    start_run("ign2");
    wait_done("ign2");
    check_results("ign2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
